write_ptr_block: RTL and testbench

Write-domain pointer and full-flag generator for the async FIFO. It is the upstream counterpart of read_ptr_block. It holds the binary and Gray write pointers. Its g_wptr output is passed through the 2-flop synchronizer into the read domain, where it becomes g_wptr_sync. It consumes the read pointer after that pointer is synchronized into w_clk (g_rptr_sync). From it, the block generates full, almost_full, fill level, a sticky overflow flag, and the memory write strobe and address.

---
 rtl/write_ptr_block_pkg.sv | 11 +
 rtl/write_ptr_block_if.sv | 26 ++
 rtl/write_ptr_block_gray2bin.sv | 12 +
 rtl/write_ptr_block.sv | 69 ++++++
 tb/tb_write_ptr_block.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/write_ptr_block_pkg.sv
// Shared async-FIFO definitions: default geometry and the binary-to-Gray helper
// used by both pointer blocks.
package fifo_pkg;
   localparam int ADDR_WIDTH = 3;
   localparam int PTR_W      = ADDR_WIDTH + 1;

   // Width-agnostic: callers cast in and out of 32 bits.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction
endpackage

// File: rtl/write_ptr_block_if.sv
// Write-side FIFO pointer bus. The master modport belongs to the producer or
// CDC wrapper, and the slave modport belongs to write_ptr_block.
interface write_ptr_block_if #(
   parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
);
   logic                  w_en;
   logic [ADDR_WIDTH:0]   g_rptr_sync;
   logic [ADDR_WIDTH:0]   g_wptr;
   logic [ADDR_WIDTH:0]   b_wptr;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  wr_fire;
   logic                  full;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   fill_level;
   logic                  overflow;

   modport master (
      output w_en, g_rptr_sync,
      input  g_wptr, b_wptr, w_addr, wr_fire, full, almost_full, fill_level, overflow
   );

   modport slave (
      input  w_en, g_rptr_sync,
      output g_wptr, b_wptr, w_addr, wr_fire, full, almost_full, fill_level, overflow
   );
endinterface

// File: rtl/write_ptr_block_gray2bin.sv
// Combinational Gray-to-binary converter. Each output bit is the XOR of the
// Gray bits from the MSB down to that bit's position.
module gray2bin #(
   parameter int WIDTH = fifo_pkg::PTR_W
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[WIDTH-1:i];
   end
endmodule

// File: rtl/write_ptr_block.sv
// Write-domain pointer pair and full/level flags for the async FIFO. The
// synchronized Gray read pointer is compared against the next write pointer.
module write_ptr_block #(
   parameter int ADDR_WIDTH     = fifo_pkg::ADDR_WIDTH,
   parameter int ALMOST_FULL_TH = 6
) (
   input  logic               w_clk,
   input  logic               wrst,
   write_ptr_block_if.slave   bus
);
   localparam int PTR_W = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0] AF_TH = PTR_W'(ALMOST_FULL_TH);

   logic [PTR_W-1:0] b_q, b_d;
   logic [PTR_W-1:0] g_q, g_d;
   logic [PTR_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             af_q, af_d;
   logic             ovf_q, ovf_d;
   logic             fire;
   logic [PTR_W-1:0] b_rsync;
   logic [PTR_W-1:0] g_rptr_lap;

   gray2bin #(.WIDTH(PTR_W)) u_rsync (
      .gray_i (bus.g_rptr_sync),
      .bin_o  (b_rsync)
   );

   assign fire = bus.w_en & ~full_q;

   // In Gray code, "one lap ahead" means the top two bits are inverted.
   assign g_rptr_lap = {~bus.g_rptr_sync[PTR_W-1:PTR_W-2], bus.g_rptr_sync[PTR_W-3:0]};

   always_comb begin
      b_d     = b_q + {{ADDR_WIDTH{1'b0}}, fire};
      g_d     = PTR_W'(fifo_pkg::bin2gray(32'(b_d)));
      level_d = b_d - b_rsync;
      full_d  = (g_d == g_rptr_lap);
      af_d    = (level_d >= AF_TH);
      ovf_d   = ovf_q | (bus.w_en & full_q);
   end

   always_ff @(posedge w_clk or posedge wrst) begin
      if (wrst) begin
         b_q     <= '0;
         g_q     <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         b_q     <= b_d;
         g_q     <= g_d;
         level_q <= level_d;
         full_q  <= full_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.g_wptr      = g_q;
   assign bus.b_wptr      = b_q;
   assign bus.w_addr      = b_q[ADDR_WIDTH-1:0];
   assign bus.wr_fire     = fire;
   assign bus.full        = full_q;
   assign bus.almost_full = af_q;
   assign bus.fill_level  = level_q;
   assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_write_ptr_block.sv
// Bench for write_ptr_block: directed scenarios plus randomized traffic checked
// against an occupancy-count model of the FIFO write side.
module tb_write_ptr_block;
   logic w_clk;
   logic wrst;
   int   total = 0;
   int   bad   = 0;

   write_ptr_block_if #(.ADDR_WIDTH(3)) bus ();

   write_ptr_block #(.ADDR_WIDTH(3), .ALMOST_FULL_TH(6)) dut (
      .w_clk (w_clk),
      .wrst  (wrst),
      .bus   (bus.slave)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   // Reference model: write and read positions modulo 16. Occupancy is their difference.
   int   m_wr, m_rd;
   logic m_full, m_af, m_ovf;
   int   m_level;
   logic fire_exp, fire_obs;

   function automatic logic [3:0] gray4(input int v);
      logic [3:0] b;
      b = 4'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [14:0] exp_vec();
      return {gray4(m_wr), 4'(m_wr), m_full, m_af, 4'(m_level), m_ovf};
   endfunction

   function automatic logic [14:0] obs_vec();
      return {bus.g_wptr, bus.b_wptr, bus.full, bus.almost_full, bus.fill_level, bus.overflow};
   endfunction

   task automatic model_clear();
      m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_ovf = 0; m_level = 0;
   endtask

   // Drive one cycle of inputs, capture wr_fire before the edge, then step the model.
   task automatic cyc(input logic en, input int rd_new);
      bus.w_en        = en;
      m_rd            = rd_new % 16;
      bus.g_rptr_sync = gray4(m_rd);
      #1;
      fire_exp = en & ~m_full;
      fire_obs = bus.wr_fire;
      @(posedge w_clk);
      m_ovf   = m_ovf | (en & m_full);
      if (fire_exp) m_wr = (m_wr + 1) % 16;
      m_level = (m_wr - m_rd + 16) % 16;
      m_full  = (m_level == 8);
      m_af    = (m_level >= 6);
      #1;
   endtask

   task automatic do_reset();
      wrst = 1'b1;
      bus.w_en = 1'b0;
      bus.g_rptr_sync = 4'b0000;
      #2;
      wrst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      wrst = 1'b1;
      bus.w_en = 1'b1;
      bus.g_rptr_sync = 4'b0000;
      #2;
      total++;
      if (obs_vec() !== 15'd0) begin
         bad++; $display("FAIL reset_async: got %h want 0", obs_vec());
      end
      total++;
      if (bus.wr_fire !== 1'b1) begin
         bad++; $display("FAIL reset_wr_fire: got %b want 1", bus.wr_fire);
      end
      @(posedge w_clk); #1;
      total++;
      if (obs_vec() !== 15'd0) begin
         bad++; $display("FAIL reset_held: got %h want 0", obs_vec());
      end
      wrst = 1'b0;
      model_clear();
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 0);
         total++;
         if (obs_vec() !== 15'd0) begin
            bad++; $display("FAIL reset_idle[%0d]: got %h want 0", i, obs_vec());
         end
      end
   endtask

   task automatic test_fill();
      logic [3:0] gseq [8];
      gseq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 0);
         total++;
         if (fire_obs !== 1'b1) begin
            bad++; $display("FAIL fill_fire[%0d]: got %b want 1", i, fire_obs);
         end
         total++;
         if (bus.g_wptr !== gseq[i]) begin
            bad++; $display("FAIL fill_gray[%0d]: got %h want %h", i, bus.g_wptr, gseq[i]);
         end
         total++;
         if (bus.almost_full !== (i >= 5)) begin
            bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, (i >= 5));
         end
         total++;
         if (bus.full !== (i == 7) || bus.fill_level !== 4'(i + 1)) begin
            bad++; $display("FAIL fill_full_lvl[%0d]: got %b/%0d want %b/%0d",
                            i, bus.full, bus.fill_level, (i == 7), i + 1);
         end
      end
   endtask

   task automatic test_write_full();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 0);
         total++;
         if (fire_obs !== 1'b0 || bus.b_wptr !== 4'd8 || bus.overflow !== 1'b1) begin
            bad++; $display("FAIL wfull[%0d]: fire=%b b=%0d ovf=%b want 0/8/1",
                            i, fire_obs, bus.b_wptr, bus.overflow);
         end
      end
      cyc(1'b0, 0);
      total++;
      if (bus.overflow !== 1'b1 || bus.full !== 1'b1) begin
         bad++; $display("FAIL wfull_sticky: ovf=%b full=%b want 1/1", bus.overflow, bus.full);
      end
   endtask

   task automatic test_drain_one();
      cyc(1'b0, 1);
      total++;
      if (bus.full !== 1'b0 || bus.fill_level !== 4'd7) begin
         bad++; $display("FAIL drain: full=%b lvl=%0d want 0/7", bus.full, bus.fill_level);
      end
      cyc(1'b1, 1);
      total++;
      if (bus.b_wptr !== 4'd9 || bus.g_wptr !== 4'b1101 || bus.full !== 1'b1) begin
         bad++; $display("FAIL drain_refill: b=%0d g=%b full=%b want 9/1101/1",
                         bus.b_wptr, bus.g_wptr, bus.full);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1'b1, 0);
      for (int i = 1; i <= 8; i++) cyc(1'b0, i);
      total++;
      if (bus.b_wptr !== 4'd8 || bus.fill_level !== 4'd0 || bus.full !== 1'b0) begin
         bad++; $display("FAIL wrap_setup: b=%0d lvl=%0d full=%b want 8/0/0",
                         bus.b_wptr, bus.fill_level, bus.full);
      end
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 8);
         total++;
         if (bus.b_wptr !== 4'((9 + i) % 16)) begin
            bad++; $display("FAIL wrap_b[%0d]: got %0d want %0d", i, bus.b_wptr, (9 + i) % 16);
         end
      end
      total++;
      if (bus.g_wptr !== 4'b0000 || bus.full !== 1'b1 || bus.fill_level !== 4'd8 ||
          bus.overflow !== 1'b0 || bus.w_addr !== 3'd0) begin
         bad++; $display("FAIL wrap_end: g=%b full=%b lvl=%0d ovf=%b addr=%0d want 0000/1/8/0/0",
                         bus.g_wptr, bus.full, bus.fill_level, bus.overflow, bus.w_addr);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1'b1, 0);
      total++;
      if (bus.b_wptr !== 4'd5) begin
         bad++; $display("FAIL midrst_pre: b=%0d want 5", bus.b_wptr);
      end
      #2;
      wrst = 1'b1;
      #1;
      total++;
      if (obs_vec() !== 15'd0) begin
         bad++; $display("FAIL midrst_async: got %h want 0", obs_vec());
      end
      @(posedge w_clk); #1;
      wrst = 1'b0;
      model_clear();
      for (int i = 0; i < 8; i++) cyc(1'b1, 0);
      total++;
      if (obs_vec() !== exp_vec() || bus.b_wptr !== 4'd8 || bus.full !== 1'b1) begin
         bad++; $display("FAIL midrst_refill: got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      int rd;
      logic en;
      do_reset();
      rd = 0;
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 99) < 60);
         if (rd != m_wr && $urandom_range(0, 99) < 45) rd = (rd + 1) % 16;
         cyc(en, rd);
         total++;
         if (fire_obs !== fire_exp) begin
            bad++; $display("FAIL rand_fire[%0d]: got %b want %b", i, fire_obs, fire_exp);
         end
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL rand_state[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
         total++;
         if (bus.w_addr !== 3'(m_wr)) begin
            bad++; $display("FAIL rand_addr[%0d]: got %0d want %0d", i, bus.w_addr, m_wr % 8);
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_fill();
      test_write_full();
      test_drain_one();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
